// File: rtl/router_pkg.sv
// ----------------------------------------------------------------------------
// router_pkg
// Shared definitions for the packet router control path. It holds the FSM
// state enumeration, the reserved address code, and a helper that picks one
// per-channel flag from a 3-channel vector by address.
// This package has no ports.
// ----------------------------------------------------------------------------
package router_pkg;

  typedef enum logic [2:0] {
    DECODE_ADDRESS,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    LOAD_PARITY,
    CHECK_PARITY_ERROR,
    WAIT_TILL_EMPTY
  } router_state_e;

  // Header address code that selects no output channel.
  localparam logic [1:0] ADDR_INVALID = 2'b11;

  // Returns the flag of channel 'addr'. The invalid code returns 0, so it
  // never selects a channel.
  function automatic logic chan_sel(input logic [2:0] flags, input logic [1:0] addr);
    logic sel;
    case (addr)
      2'd0:    sel = flags[0];
      2'd1:    sel = flags[1];
      2'd2:    sel = flags[2];
      default: sel = 1'b0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/router_fsm_if.sv
// ----------------------------------------------------------------------------
// router_fsm_if
// Groups the handshake and status signals between the router FSM and its
// neighbours: the packet source, the output FIFOs, the synchronizer and the
// register stage.
//   master modport : drives the FSM inputs and observes the FSM outputs
//                    (system side / testbench)
//   slave  modport : the FSM itself
// Signals:
//   pkt_valid, data_in[1:0]      source byte-valid flag and header address bits
//   fifo_full                    full flag of the selected output FIFO
//   fifo_empty_0/1/2             empty flags of the output FIFOs
//   soft_reset_0/1/2             per-channel timeout resets
//   parity_done, low_pkt_valid   status from the register stage
//   busy                         stall request to the source
//   detect_add, lfd_state, ld_state, laf_state, full_state
//                                state decodes sent to the register stage
//   write_enb_reg                FIFO write enable request
//   rst_int_reg                  clears low_pkt_valid in the register stage
// ----------------------------------------------------------------------------
interface router_fsm_if;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       parity_done;
  logic       low_pkt_valid;

  logic       busy;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       write_enb_reg;
  logic       rst_int_reg;

  modport master (
    output pkt_valid, data_in, fifo_full,
           fifo_empty_0, fifo_empty_1, fifo_empty_2,
           soft_reset_0, soft_reset_1, soft_reset_2,
           parity_done, low_pkt_valid,
    input  busy, detect_add, lfd_state, ld_state, laf_state, full_state,
           write_enb_reg, rst_int_reg
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full,
           fifo_empty_0, fifo_empty_1, fifo_empty_2,
           soft_reset_0, soft_reset_1, soft_reset_2,
           parity_done, low_pkt_valid,
    output busy, detect_add, lfd_state, ld_state, laf_state, full_state,
           write_enb_reg, rst_int_reg
  );
endinterface

// File: rtl/router_fsm.sv
// ----------------------------------------------------------------------------
// router_fsm
// Control FSM for a 3-channel packet router. It decodes the header address,
// sequences the load of header, payload and parity into the selected output
// FIFO, stalls the source while the FIFO is full, and waits for an occupied
// FIFO to drain before it starts a packet. Outputs are Moore decodes of a
// single state register.
// Ports:
//   clock   rising-edge clock
//   resetn  synchronous active-low reset
//   bus     router_fsm_if.slave; holds all handshake and status signals
// ----------------------------------------------------------------------------
module router_fsm
  import router_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  router_fsm_if.slave bus
);

  router_state_e state_q, state_d;
  logic [1:0]    addr_q, addr_d;

  logic [2:0] empty_vec, soft_vec;
  logic       hdr_ok;

  assign empty_vec = {bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
  assign soft_vec  = {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};

  // A header is accepted only while the source is valid and the address is
  // not the reserved code.
  assign hdr_ok = bus.pkt_valid && (bus.data_in != ADDR_INVALID);

  // State register and address latch.
  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples the value from before the edge, whatever the statement order.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state logic and address latch update.
  // NOTE: every signal gets a default first, so no path through the case
  // leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;

    if (state_q == DECODE_ADDRESS && hdr_ok)
      addr_d = bus.data_in;

    case (state_q)
      DECODE_ADDRESS: begin
        if (hdr_ok)
          state_d = chan_sel(empty_vec, bus.data_in) ? LOAD_FIRST_DATA
                                                     : WAIT_TILL_EMPTY;
      end
      WAIT_TILL_EMPTY: begin
        if (chan_sel(empty_vec, addr_q))
          state_d = LOAD_FIRST_DATA;
      end
      LOAD_FIRST_DATA: state_d = LOAD_DATA;
      LOAD_DATA: begin
        if (bus.fifo_full)
          state_d = FIFO_FULL_STATE;
        else if (!bus.pkt_valid)
          state_d = LOAD_PARITY;
      end
      FIFO_FULL_STATE: begin
        if (!bus.fifo_full)
          state_d = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (bus.parity_done)
          state_d = DECODE_ADDRESS;
        else if (bus.low_pkt_valid)
          state_d = LOAD_PARITY;
        else
          state_d = LOAD_DATA;
      end
      LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: begin
        state_d = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      end
      default: state_d = DECODE_ADDRESS;
    endcase

    // A timeout on the channel in use aborts the packet from any state.
    // Timeouts on the other channels are ignored.
    if (chan_sel(soft_vec, addr_q))
      state_d = DECODE_ADDRESS;
  end

  // Moore output decode.
  always_comb begin
    bus.detect_add    = 1'b0;
    bus.lfd_state     = 1'b0;
    bus.ld_state      = 1'b0;
    bus.laf_state     = 1'b0;
    bus.full_state    = 1'b0;
    bus.rst_int_reg   = 1'b0;
    bus.write_enb_reg = 1'b0;
    bus.busy          = 1'b1;
    case (state_q)
      DECODE_ADDRESS:     begin bus.detect_add = 1'b1; bus.busy = 1'b0; end
      LOAD_FIRST_DATA:    bus.lfd_state = 1'b1;
      LOAD_DATA:          begin bus.ld_state = 1'b1; bus.write_enb_reg = 1'b1; bus.busy = 1'b0; end
      FIFO_FULL_STATE:    bus.full_state = 1'b1;
      LOAD_AFTER_FULL:    begin bus.laf_state = 1'b1; bus.write_enb_reg = 1'b1; end
      LOAD_PARITY:        bus.write_enb_reg = 1'b1;
      CHECK_PARITY_ERROR: bus.rst_int_reg = 1'b1;
      default:            ;  // WAIT_TILL_EMPTY: only busy
    endcase
  end

endmodule
